// File: rtl/alu_mult_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_mult_sequencer_pkg
// Shared definitions for the shift-add multiplier sequencer: the opcodes of
// the shared 32-bit ALU and the sequencer FSM state encoding.
// ---------------------------------------------------------------------------
package alu_mult_sequencer_pkg;

    // Opcodes understood by the shared ALU (4-bit operation field).
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_LUI = 4'b0111;

    // Sequencer states: one ADD per set multiplier bit, one SHIFT per bit
    // position up to the highest set bit, then a single DONE cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : alu_mult_sequencer_pkg

// File: rtl/alu_mult_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_mult_sequencer_if
// Bundles the request/response handshake of the multiplier together with the
// ALU borrow port (the operands it drives to the shared ALU and the result it
// reads back in the same cycle).
//   start, multiplicand, multiplier : request side, driven by the requester
//   busy, done, product             : status/result, driven by the sequencer
//   alu_operation/a/b/shamt         : ALU inputs, driven by the sequencer
//   alu_result                      : combinational ALU output, read back
// Modports: slave = the sequencer, master = requester plus ALU datapath.
// ---------------------------------------------------------------------------
interface alu_mult_sequencer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int OP_WIDTH    = 4
) ();

    logic                   start;
    logic [DATA_WIDTH-1:0]  multiplicand;
    logic [DATA_WIDTH-1:0]  multiplier;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  product;
    logic [OP_WIDTH-1:0]    alu_operation;
    logic [DATA_WIDTH-1:0]  alu_a;
    logic [DATA_WIDTH-1:0]  alu_b;
    logic [SHAMT_WIDTH-1:0] alu_shamt;
    logic [DATA_WIDTH-1:0]  alu_result;

    modport slave (
        input  start, multiplicand, multiplier, alu_result,
        output busy, done, product, alu_operation, alu_a, alu_b, alu_shamt
    );

    modport master (
        output start, multiplicand, multiplier, alu_result,
        input  busy, done, product, alu_operation, alu_a, alu_b, alu_shamt
    );

endinterface : alu_mult_sequencer_if

// File: rtl/alu_mult_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mult_sequencer
// Multicycle shift-add multiplier that owns no adder: it borrows the shared
// ALU (selected by an external mux while busy=1) and sequences ADD and SLL
// operations on it. Returns the low DATA_WIDTH bits of a*b, identical for
// signed and unsigned operands.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low; returns FSM to IDLE, clears outputs
//   bus    : alu_mult_sequencer_if.slave
//            start/multiplicand/multiplier in, busy/done/product out,
//            alu_operation/alu_a/alu_b/alu_shamt out, alu_result in
// ---------------------------------------------------------------------------
module alu_mult_sequencer
    import alu_mult_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int OP_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_mult_sequencer_if.slave   bus
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                 state, state_next;
    logic [DATA_WIDTH-1:0]  mcand, mcand_next;
    logic [DATA_WIDTH-1:0]  mplier, mplier_next;
    logic [DATA_WIDTH-1:0]  acc, acc_next;
    logic [CNT_WIDTH-1:0]   cnt, cnt_next;
    logic                   done_q;
    logic [DATA_WIDTH-1:0]  product_q;

    logic [OP_WIDTH-1:0]    alu_op_c;
    logic [DATA_WIDTH-1:0]  alu_a_c;
    logic [DATA_WIDTH-1:0]  alu_b_c;
    logic [SHAMT_WIDTH-1:0] alu_shamt_c;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state  <= state_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            acc    <= acc_next;
            cnt    <= cnt_next;
            // done and product are registered on entry to DONE, so both are
            // clean flop outputs during the DONE cycle.
            done_q <= (state_next == ST_DONE);
            if (state_next == ST_DONE) begin
                product_q <= acc_next;
            end
        end
    end

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        mplier_next = mplier;
        acc_next    = acc;
        cnt_next    = cnt;
        alu_op_c    = OP_WIDTH'(ALU_AND);
        alu_a_c     = '0;
        alu_b_c     = '0;
        alu_shamt_c = '0;

        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    mcand_next  = bus.multiplicand;
                    mplier_next = bus.multiplier;
                    acc_next    = '0;
                    cnt_next    = '0;
                    if (bus.multiplier == '0) begin
                        state_next = ST_DONE;
                    end else if (bus.multiplier[0]) begin
                        state_next = ST_ADD;
                    end else begin
                        state_next = ST_SHIFT;
                    end
                end
            end

            ST_ADD: begin
                alu_op_c   = OP_WIDTH'(ALU_ADD);
                alu_a_c    = acc;
                alu_b_c    = mcand;
                acc_next   = bus.alu_result;
                state_next = ST_SHIFT;
            end

            ST_SHIFT: begin
                // The ALU doubles the multiplicand; the multiplier is
                // consumed one bit per shift, so mplier[1] is the bit that
                // decides whether the next step is an ADD.
                alu_op_c    = OP_WIDTH'(ALU_SLL);
                alu_b_c     = mcand;
                alu_shamt_c = SHAMT_WIDTH'(1);
                mcand_next  = bus.alu_result;
                mplier_next = mplier >> 1;
                cnt_next    = cnt + 1'b1;
                if (mplier_next == '0 || cnt == CNT_LAST) begin
                    state_next = ST_DONE;
                end else if (mplier[1]) begin
                    state_next = ST_ADD;
                end else begin
                    state_next = ST_SHIFT;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ALU drive is decoded from the state register alone, so an asynchronous
    // reset forces it back to AND/0/0/0 without waiting for a clock edge.
    assign bus.busy          = (state != ST_IDLE);
    assign bus.done          = done_q;
    assign bus.product       = product_q;
    assign bus.alu_operation = alu_op_c;
    assign bus.alu_a         = alu_a_c;
    assign bus.alu_b         = alu_b_c;
    assign bus.alu_shamt     = alu_shamt_c;

endmodule : alu_mult_sequencer

// File: tb/tb_alu_mult_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mult_sequencer
// Self-checking bench for alu_mult_sequencer. Provides the shared ALU as a
// behavioural model, drives directed and random multiplications, and compares
// product, done latency, busy and the ALU operation sequence against values
// derived from the operands with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_mult_sequencer;

    localparam int DW = 32;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0101;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_mult_sequencer_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(5), .OP_WIDTH(4)) bus ();

    alu_mult_sequencer #(.DATA_WIDTH(DW), .SHAMT_WIDTH(5), .OP_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared ALU, as seen through the busy-selected mux.
    always_comb begin
        case (bus.alu_operation)
            OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
            OP_SLL:  bus.alu_result = bus.alu_b << bus.alu_shamt;
            OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---- reference model ---------------------------------------------------
    function automatic int popcount(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    // Number of bit positions the multiplier spans (highest set bit + 1).
    function automatic int span(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    // Last eight non-AND ALU opcodes, one nibble each: every bit position
    // of b up to its highest set bit costs an SLL, preceded by an ADD if set.
    function automatic logic [31:0] exp_seq(input logic [31:0] b);
        logic [31:0] s = '0;
        for (int i = 0; i < span(b); i++) begin
            if (b[i]) s = {s[27:0], OP_ADD};
            s = {s[27:0], OP_SLL};
        end
        return s;
    endfunction

    // Caller must be at a negedge with the FSM idle. Drives the request,
    // lets the next posedge accept it, then follows the run to done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit keep_start, input string tag);
        logic [31:0] prev_prod;
        logic [31:0] seq;
        int          cyc;
        int          n_ops;
        bit          held;
        bit          busy_ok;
        logic [31:0] exp_prod;
        exp_prod         = a * b;
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        prev_prod        = bus.product;
        @(posedge clk);
        cyc = 0; n_ops = 0; seq = '0; held = 1'b1; busy_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (!keep_start) bus.start = 1'b0;
            if (bus.alu_operation != OP_AND) begin
                n_ops++;
                seq = {seq[27:0], bus.alu_operation};
            end
            if (!bus.busy) busy_ok = 1'b0;
            if (!bus.done) begin
                if (bus.product !== prev_prod) held = 1'b0;
                // Operands changing after accept must not matter.
                bus.multiplicand = $urandom;
                bus.multiplier   = $urandom;
            end
        end while (!bus.done && cyc < 200);
        check({tag, ".product"}, bus.product, exp_prod);
        check({tag, ".latency"}, 32'(cyc), 32'(popcount(b) + span(b) + 1));
        check({tag, ".alu_ops"}, 32'(n_ops), 32'(popcount(b) + span(b)));
        check({tag, ".alu_seq"}, seq, exp_seq(b));
        check({tag, ".busy"}, 32'(busy_ok), 32'd1);
        check({tag, ".held"}, 32'(held), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        checks = 0; failures = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        #1;
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.product", bus.product, 32'd0);
        check("rst.alu_op", 32'(bus.alu_operation), 32'(OP_AND));
        check("rst.alu_ab", bus.alu_a | bus.alu_b, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // a=3, b=5: ADD, SLL, SLL, ADD, SLL; done in cycle 6.
        run_op(32'd3, 32'd5, 1'b0, "mul3x5");
        check("mul3x5.seq", bus.product, 32'd15);

        // Reset in cycle 3 of a 7*9 run: everything clears at once.
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd7; bus.multiplier = 32'd9;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.done", 32'(bus.done), 32'd0);
        check("midrst.product", bus.product, 32'd0);
        check("midrst.alu_op", 32'(bus.alu_operation), 32'(OP_AND));
        check("midrst.alu_a", bus.alu_a, 32'd0);
        check("midrst.alu_b", bus.alu_b, 32'd0);
        check("midrst.shamt", 32'(bus.alu_shamt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(32'd7, 32'd9, 1'b0, "after_rst");

        @(negedge clk);
        run_op(32'h1234, 32'd0, 1'b0, "b_zero");
        @(negedge clk);
        run_op(32'd2, 32'hFFFF_FFFF, 1'b0, "b_ones");
        @(negedge clk);
        run_op(32'h8000_0000, 32'd2, 1'b0, "wrap");
        @(negedge clk);
        run_op(32'h8000_0001, 32'h8000_0000, 1'b0, "b_msb");

        // start held: ignored while busy, re-accepted after one IDLE cycle.
        @(negedge clk);
        run_op(32'd11, 32'd13, 1'b1, "hold1");
        bus.multiplicand = 32'd6; bus.multiplier = 32'd7;
        @(negedge clk);
        check("hold.idle_gap", 32'(bus.busy), 32'd0);
        check("hold.prev_product", bus.product, 32'd143);
        run_op(32'd6, 32'd7, 1'b0, "hold2");

        // Random operands; a quarter use a short multiplier.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ((i % 4) == 0) rb = rb & 32'h0000_00FF;
            @(negedge clk);
            run_op(ra, rb, 1'b0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_mult_sequencer
